pkt_data_cache: RTL and testbench
=================================

Name: pkt_data_cache

Overview:
- Packet payload buffer placed alongside packet_header_parser. It consumes the same AXI-Stream input and holds whole packets while the PHV is being processed.
- Stored packets are released to the master AXI-Stream output, or discarded, one per token from the downstream processing stage.
- Forwarding is store-and-forward. A packet is only eligible for release once its tlast beat is stored.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width; tuser is stored with every beat.
- DEPTH_BITS, 4, log2 of FIFO depth in beats (default 16 beats).
- PKT_CNT_BITS, 5, width of the stored-complete-packet counter.

Ports:
- axis_clk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input beat data.
- s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when high with tvalid.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tdata / m_axis_tkeep / m_axis_tuser / m_axis_tlast  out  same widths  head-of-FIFO beat.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- rel_valid  in  1  release token valid.
- rel_drop  in  1  qualifies the token: 1 = discard the packet, 0 = forward it.
- rel_ready  out  1  token accepted when high with rel_valid.
- err_oversize  out  1  sticky error flag.
- stat_sent  out  32  packets forwarded.
- stat_dropped  out  32  packets discarded.

Behaviour:
- Reset values (async, aresetn=0): FIFO pointers=0, pkt_cnt=0, state=IDLE, all outputs 0 except s_axis_tready=0. s_axis_tready rises the first cycle after reset is released.
- Write side:
  - s_axis_tready = !full.
  - Each accepted beat writes {tdata,tkeep,tuser,tlast} at wr_ptr; wr_ptr increments and wraps modulo 2^DEPTH_BITS.
  - full/empty use an extra pointer MSB.
- pkt_cnt:
  - +1 on an accepted beat with tlast=1.
  - -1 when a tlast beat is popped, whether sent or dropped.
  - Both in the same cycle: unchanged.
  - Never exceeds 2^DEPTH_BITS, so PKT_CNT_BITS ≥ DEPTH_BITS+1.
- FSM states:
  - IDLE:
    - rel_ready = (pkt_cnt != 0).
    - On rel_valid & rel_ready: go to DROP if rel_drop=1, else SEND.
  - SEND:
    - m_axis_tvalid = 1; m_axis_* = FIFO head (fall-through, no extra register).
    - Pop on m_axis_tready.
    - Popping a tlast beat returns to IDLE.
    - m_axis_tvalid must not drop while waiting for tready, and the data must hold stable.
  - DROP:
    - m_axis_tvalid = 0.
    - Pop one beat per cycle unconditionally.
    - Popping a tlast beat returns to IDLE.
- Latency:
  - A packet whose tlast is accepted in cycle t can have its token accepted at t+1 at the earliest.
  - In SEND, the first output beat is valid in the cycle after the token handshake.
  - Back-to-back tokens: IDLE lasts at least one cycle between packets.
- Reading and writing the same FIFO entry is impossible: a packet is only read when complete, so a write never targets an unread entry.
- Oversize: if full=1 while pkt_cnt=0, the packet exceeds the FIFO and the input is deadlocked.
  - err_oversize sets and stays set until reset.
  - No recovery is defined. Packets are required to be ≤ 2^DEPTH_BITS beats.
- rel_valid with pkt_cnt=0: the token is held off (rel_ready=0), not lost.
- Reset mid-packet: all stored data is discarded and the FSM returns to IDLE.

Optional Feature:
- Macro: PKT_CACHE_STATS_EN.
- Defined:
  - stat_sent increments when a tlast beat is popped in SEND.
  - stat_dropped increments when a tlast beat is popped in DROP.
  - Both are 32-bit, wrap to 0 past 2^32-1, and reset to 0.
- Undefined: both outputs are tied to 0 and no counter registers are inferred.

Test Plan:
- Single packet of 3 beats (data 0x11,0x22,0x33, tlast on beat 3), then rel_valid=1, rel_drop=0 with m_axis_tready=1:
  - rel_ready is 0 until the cycle after beat 3 is accepted.
  - Output is 3 beats in order with tlast on the third, tuser/tkeep intact.
  - stat_sent=1.
- Two packets (2 beats, then 4 beats):
  - Token 1 with drop=1: packet A is popped in 2 cycles with no m_axis_tvalid.
  - Token 2 with drop=0: packet B is output intact.
  - stat_dropped=1, stat_sent=1, pkt_cnt ends at 0.
- Backpressure: m_axis_tready toggles 1,0,0,1 during SEND:
  - m_axis_tvalid stays 1 and data is stable while tready=0.
  - No beat is duplicated or lost.
- Fill: DEPTH_BITS=4, write two 8-beat packets with no token:
  - s_axis_tready=0 after the 16th beat; err_oversize stays 0.
  - One send token frees 8 entries and s_axis_tready returns to 1.
  - Then write a 17-beat packet into an empty cache: err_oversize=1 when full.
- Simultaneous events: accept a tlast input beat in the same cycle a tlast beat pops in SEND → pkt_cnt is unchanged.
- Reset mid-SEND: deassert aresetn during beat 2 of 4 → m_axis_tvalid=0 immediately. After release, pkt_cnt=0 and rel_ready=0.

Source files
------------

// File: rtl/pkt_data_cache.sv
// Store-and-forward packet payload cache: whole packets are buffered and then sent or dropped, one per release token.
// Optional per-packet counters are built only when PKT_CACHE_STATS_EN is defined.
module pkt_data_cache #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_BITS           = 4,
  parameter int PKT_CNT_BITS         = 5
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  input  logic                              rel_valid,
  input  logic                              rel_drop,
  output logic                              rel_ready,
  output logic                              err_oversize,
  output logic [31:0]                       stat_sent,
  output logic [31:0]                       stat_dropped
);

  localparam int KEEP_W  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int DEPTH   = 1 << DEPTH_BITS;
  localparam int U_LO    = 1;
  localparam int K_LO    = U_LO + C_S_AXIS_TUSER_WIDTH;
  localparam int D_LO    = K_LO + KEEP_W;
  localparam int ENTRY_W = D_LO + C_S_AXIS_DATA_WIDTH;
  localparam logic [DEPTH_BITS:0]   PTR_ONE = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [PKT_CNT_BITS-1:0] CNT_ONE = {{(PKT_CNT_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  logic [ENTRY_W-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PKT_CNT_BITS-1:0] pkt_cnt_q, pkt_cnt_d;
  state_e                  state_q, state_d;
  logic                    in_rdy_q;
  logic                    err_q, err_d;
  logic                    full_s, empty_s, wr_en_s, pop_s, head_last_s;
  logic [ENTRY_W-1:0]      head_s;

  assign full_s  = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  // in_rdy_q keeps tready low through reset and for the first edge after release
  assign s_axis_tready = in_rdy_q & ~full_s;
  assign wr_en_s       = s_axis_tvalid & s_axis_tready;
  assign head_s        = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];
  assign head_last_s   = head_s[0];

  assign m_axis_tdata = m_axis_tvalid ? head_s[ENTRY_W-1:D_LO] : {C_S_AXIS_DATA_WIDTH{1'b0}};
  assign m_axis_tkeep = m_axis_tvalid ? head_s[D_LO-1:K_LO] : {KEEP_W{1'b0}};
  assign m_axis_tuser = m_axis_tvalid ? head_s[K_LO-1:U_LO] : {C_S_AXIS_TUSER_WIDTH{1'b0}};
  assign m_axis_tlast = m_axis_tvalid & head_last_s;
  assign err_oversize = err_q;

  // Beat storage; a write never targets an entry still waiting to be read.
  always_ff @(posedge axis_clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    end
  end

  // Release FSM: a token picks SEND or DROP for the oldest complete packet.
  always_comb begin
    state_d       = state_q;
    rel_ready     = 1'b0;
    m_axis_tvalid = 1'b0;
    pop_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rel_ready = (pkt_cnt_q != {PKT_CNT_BITS{1'b0}});
        if (rel_valid && rel_ready) begin
          state_d = rel_drop ? ST_DROP : ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        m_axis_tvalid = 1'b1;
        pop_s         = m_axis_tready & ~empty_s;
        if (pop_s && head_last_s) state_d = ST_IDLE;
        else                      state_d = ST_SEND;
      end
      ST_DROP: begin
        pop_s = ~empty_s;
        if (pop_s && head_last_s) state_d = ST_IDLE;
        else                      state_d = ST_DROP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer, packet-count and sticky-error next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (wr_en_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
    else         wr_ptr_d = wr_ptr_q;
    if (pop_s)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    else         rd_ptr_d = rd_ptr_q;
    case ({wr_en_s & s_axis_tlast, pop_s & head_last_s})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    // Full with no complete packet stored can never drain: the input is deadlocked.
    err_d = err_q | (full_s & (pkt_cnt_q == {PKT_CNT_BITS{1'b0}}));
  end

  // Control state registers.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= {(DEPTH_BITS+1){1'b0}};
      rd_ptr_q  <= {(DEPTH_BITS+1){1'b0}};
      pkt_cnt_q <= {PKT_CNT_BITS{1'b0}};
      state_q   <= ST_IDLE;
      in_rdy_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      state_q   <= state_d;
      in_rdy_q  <= 1'b1;
      err_q     <= err_d;
    end
  end

`ifdef PKT_CACHE_STATS_EN
  logic [31:0] sent_q, dropped_q;

  // Per-packet counters, bumped when the tlast beat leaves the FIFO.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      sent_q    <= 32'd0;
      dropped_q <= 32'd0;
    end else begin
      if (pop_s && head_last_s && (state_q == ST_SEND)) sent_q <= sent_q + 32'd1;
      else                                              sent_q <= sent_q;
      if (pop_s && head_last_s && (state_q == ST_DROP)) dropped_q <= dropped_q + 32'd1;
      else                                              dropped_q <= dropped_q;
    end
  end

  assign stat_sent    = sent_q;
  assign stat_dropped = dropped_q;
`else
  assign stat_sent    = 32'd0;
  assign stat_dropped = 32'd0;
`endif

endmodule

// File: tb/tb_pkt_data_cache.sv
// Bench for pkt_data_cache: directed scenarios plus random traffic against a packet-queue reference model.
module tb_pkt_data_cache;

  localparam int DW    = 256;
  localparam int UW    = 128;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 16;
`ifdef PKT_CACHE_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk;
  logic          aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic          rel_valid, rel_drop, rel_ready, err_oversize;
  logic [31:0]   stat_sent, stat_dropped;

  pkt_data_cache dut (
    .axis_clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .rel_valid(rel_valid), .rel_drop(rel_drop), .rel_ready(rel_ready),
    .err_oversize(err_oversize), .stat_sent(stat_sent), .stat_dropped(stat_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stored beats in arrival order, complete-packet count, release mode.
  beat_t in_q[$];
  bit    tok_q[$];
  bit    rp_q[$];
  beat_t fifo_m[$];
  int    mdl_pkts, mode;          // mode: 0 waiting for token, 1 sending, 2 dropping
  bit    rdy_m, err_m, s_acc, t_acc;
  int    sent_m, drop_m;
  int    vpct, tpct, rpct;
  int    n_checks, n_errors;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.k = {$urandom(), $urandom()};
    b.u = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.l = l;
    return b;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic push_pkt(input int len);
    for (int i = 0; i < len; i++) in_q.push_back(mk_beat(rnd_data(), (i == len - 1)));
  endtask

  task automatic check_stats();
    check_eq("stat_sent", DW'(stat_sent), DW'(STATS_ON ? sent_m : 0));
    check_eq("stat_dropped", DW'(stat_dropped), DW'(STATS_ON ? drop_m : 0));
  endtask

  // One clock: drive after the edge, check and advance the model at the falling edge.
  task automatic cycle();
    bit    exp_srdy, exp_rrdy, err_nx, wr, pop;
    beat_t b;
    @(posedge clk);
    #1;
    if (aresetn) rdy_m = 1'b1;
    if (!(s_axis_tvalid && !s_acc)) begin
      if (in_q.size() > 0 && $urandom_range(99) < vpct) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = in_q[0].d;
        s_axis_tkeep  = in_q[0].k;
        s_axis_tuser  = in_q[0].u;
        s_axis_tlast  = in_q[0].l;
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
    if (!(rel_valid && !t_acc)) begin
      if (tok_q.size() > 0 && $urandom_range(99) < tpct) begin
        rel_valid = 1'b1;
        rel_drop  = tok_q[0];
      end else begin
        rel_valid = 1'b0;
        rel_drop  = 1'($urandom_range(1));
      end
    end
    if (rp_q.size() > 0) m_axis_tready = rp_q.pop_front();
    else                 m_axis_tready = ($urandom_range(99) < rpct);
    @(negedge clk);
    exp_srdy = rdy_m && (fifo_m.size() < DEPTH);
    exp_rrdy = (mode == 0) && (mdl_pkts != 0);
    check_eq("s_tready", DW'(s_axis_tready), DW'(exp_srdy));
    check_eq("rel_ready", DW'(rel_ready), DW'(exp_rrdy));
    check_eq("m_tvalid", DW'(m_axis_tvalid), DW'(mode == 1));
    check_eq("err_oversize", DW'(err_oversize), DW'(err_m));
    check_stats();
    if (mode == 1) begin
      check_eq("m_tdata", m_axis_tdata, fifo_m[0].d);
      check_eq("m_tkeep", DW'(m_axis_tkeep), DW'(fifo_m[0].k));
      check_eq("m_tuser", DW'(m_axis_tuser), DW'(fifo_m[0].u));
      check_eq("m_tlast", DW'(m_axis_tlast), DW'(fifo_m[0].l));
    end
    err_nx = err_m || (fifo_m.size() == DEPTH && mdl_pkts == 0);
    wr     = s_axis_tvalid && exp_srdy;
    pop    = (mode == 1 && m_axis_tready) || (mode == 2);
    s_acc  = wr;
    t_acc  = rel_valid && exp_rrdy;
    if (pop) begin
      b = fifo_m.pop_front();
      if (b.l) begin
        mdl_pkts--;
        if (mode == 1) sent_m++;
        else           drop_m++;
        mode = 0;
      end
    end
    if (t_acc) begin
      mode = rel_drop ? 2 : 1;
      void'(tok_q.pop_front());
    end
    if (wr) begin
      b.d = s_axis_tdata; b.k = s_axis_tkeep; b.u = s_axis_tuser; b.l = s_axis_tlast;
      fifo_m.push_back(b);
      void'(in_q.pop_front());
      if (b.l) mdl_pkts++;
    end
    err_m = err_nx;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    bit done;
    while ((in_q.size() != 0 || tok_q.size() != 0 || mode != 0) && n < budget) begin
      cycle();
      n++;
    end
    done = (in_q.size() == 0 && tok_q.size() == 0 && mode == 0);
    check_eq("drain_done", DW'(done), DW'(1'b1));
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0; rel_valid = 1'b0; m_axis_tready = 1'b0;
    in_q.delete(); tok_q.delete(); rp_q.delete(); fifo_m.delete();
    mdl_pkts = 0; mode = 0; rdy_m = 1'b0; err_m = 1'b0; s_acc = 1'b0; t_acc = 1'b0;
    sent_m = 0; drop_m = 0;
    #1;
    check_eq("rst_m_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_tready", DW'(s_axis_tready), DW'(1'b0));
    check_eq("rst_rel_ready", DW'(rel_ready), DW'(1'b0));
    check_eq("rst_m_tdata", m_axis_tdata, DW'(1'b0));
    check_eq("rst_err", DW'(err_oversize), DW'(1'b0));
    check_stats();
    aresetn = 1'b1;
  endtask

  initial begin
    int n;
    beat_t b;
    n_checks = 0; n_errors = 0;
    vpct = 100; tpct = 100; rpct = 100;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0;
    rel_drop = 1'b0;
    do_reset();

    // Single 3-beat packet, token waiting from the start.
    for (int i = 1; i <= 3; i++) begin
      b = mk_beat(DW'(8'h11 * i), (i == 3));
      in_q.push_back(b);
    end
    tok_q.push_back(1'b0);
    run_idle(100);
    check_eq("single_sent", DW'(stat_sent), DW'(STATS_ON ? 1 : 0));

    // Drop a 2-beat packet, send a 4-beat packet.
    push_pkt(2); push_pkt(4);
    tok_q.push_back(1'b1); tok_q.push_back(1'b0);
    run_idle(100);
    check_eq("two_pkt_empty", DW'(rel_ready), DW'(1'b0));

    // Backpressure pattern during SEND.
    push_pkt(4);
    repeat (6) cycle();
    tok_q.push_back(1'b0);
    rp_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run_idle(100);

    // Fill to 16 beats without tokens, then free one packet.
    do_reset();
    push_pkt(8); push_pkt(8);
    repeat (20) cycle();
    check_eq("fill_full", DW'(s_axis_tready), DW'(1'b0));
    check_eq("fill_no_err", DW'(err_oversize), DW'(1'b0));
    tok_q.push_back(1'b0);
    run_idle(100);
    check_eq("fill_freed", DW'(s_axis_tready), DW'(1'b1));

    // Oversize packet into an empty cache.
    do_reset();
    push_pkt(17);
    repeat (24) cycle();
    check_eq("oversize_err", DW'(err_oversize), DW'(1'b1));

    // tlast in and tlast out in the same cycle.
    do_reset();
    push_pkt(1);
    repeat (3) cycle();
    push_pkt(2);
    tok_q.push_back(1'b0); tok_q.push_back(1'b0);
    run_idle(100);

    // Reset asserted in the middle of a 4-beat SEND.
    push_pkt(4);
    tok_q.push_back(1'b0);
    n = 0;
    while (!(mode == 1 && fifo_m.size() <= 3) && n < 50) begin
      cycle();
      n++;
    end
    check_eq("midsend_reached", DW'(m_axis_tvalid), DW'(1'b1));
    aresetn = 1'b0;
    #1;
    check_eq("midsend_rst_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
    do_reset();
    cycle();
    check_eq("midsend_rel_ready", DW'(rel_ready), DW'(1'b0));

    // Random traffic.
    vpct = 70; tpct = 50; rpct = 60;
    for (int p = 0; p < 60; p++) begin
      push_pkt($urandom_range(8, 1));
      tok_q.push_back(1'($urandom_range(1)));
    end
    run_idle(20000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
